// File: rtl/aes_pkg.sv
// Shared AES datapath types: state/byte words, the SubBytes FSM encoding and state size.
package aes_pkg;
   typedef logic [127:0] aes_state_t;
   typedef logic [7:0]   aes_byte_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} sb_state_e;
   localparam int AES_STATE_BYTES = 16;
endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lane: forward table always, inverse table only with SUBBYTES_INV_EN.
module aes_sbox
   import aes_pkg::*;
(
   input  aes_byte_t in_i,
   input  logic      inv_i,
   output aes_byte_t out_o
);
   // Table byte 0 sits in the top bits, so entry x lives at [2047-8x -: 8].
   localparam logic [2047:0] FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   aes_byte_t fwd_byte;
   assign fwd_byte = FWD[2047 - 8*int'(in_i) -: 8];

`ifdef SUBBYTES_INV_EN
   localparam logic [2047:0] INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   aes_byte_t inv_byte;
   assign inv_byte = INV[2047 - 8*int'(in_i) -: 8];
   assign out_o    = inv_i ? inv_byte : fwd_byte;
`else
   logic unused_inv;
   assign unused_inv = inv_i;
   assign out_o      = fwd_byte;
`endif
endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES shared S-boxes walk the 16-byte state one chunk per cycle.
// Optional SUBBYTES_INV_EN adds an 'inv' port selecting the inverse S-box for the whole state.
module sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  aes_state_t in_data,
`ifdef SUBBYTES_INV_EN
   input  logic       inv,
`endif
   output logic       out_valid,
   input  logic       out_ready,
   output aes_state_t out_data
);
   localparam int NCHUNK = AES_STATE_BYTES / LANES;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   sb_state_e     state_q;
   logic [CW-1:0] chunk_q;
   aes_state_t    work_q, work_d;
   logic          in_ready_q, out_valid_q;
   logic          inv_sel;
   aes_byte_t     sb_in  [LANES];
   aes_byte_t     sb_out [LANES];
   int            base;

`ifdef SUBBYTES_INV_EN
   logic inv_q;
   assign inv_sel = inv_q;
`else
   assign inv_sel = 1'b0;
`endif

   assign base = int'(chunk_q) * LANES;

   always_comb begin
      work_d = work_q;
      for (int l = 0; l < LANES; l++) begin
         sb_in[l] = work_q[8*(AES_STATE_BYTES-1-(base+l)) +: 8];
         work_d[8*(AES_STATE_BYTES-1-(base+l)) +: 8] = sb_out[l];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      aes_sbox u_sbox (
         .in_i  (sb_in[g]),
         .inv_i (inv_sel),
         .out_o (sb_out[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         chunk_q     <= '0;
         work_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SUBBYTES_INV_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               work_q     <= in_data;
               chunk_q    <= '0;
               in_ready_q <= 1'b0;
               state_q    <= BUSY;
`ifdef SUBBYTES_INV_EN
               inv_q      <= inv;
`endif
            end
            BUSY: begin
               work_q  <= work_d;
               chunk_q <= chunk_q + CW'(1);
               if (chunk_q == LAST) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state_q     <= IDLE;
               chunk_q     <= '0;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = work_q;
endmodule
